mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL take parameter TIMEOUT, default 16, the maximum number of BUSY cycles without dmem_ack before an access fault.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 flush  in  1  discard the current MEM-stage instruction.
REQ-005 mem_r, mem_w  in  1 each  load / store request held by the EX/MEM latch.
REQ-006 u_b_h_w  in  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; for stores, bits[1:0] select b/h/w.
REQ-007 addr  in  32  effective address (ALU output); wdata  in  32  store data.
REQ-008 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32, word-aligned; dmem_wdata  out  32; dmem_be  out  4.
REQ-009 dmem_ack  in  1; dmem_rdata  in  32.
REQ-010 stall  out  1  holds the pipeline while high.
REQ-011 load_data  out  32 and load_valid  out  1  carry the result to MEM/WB.
REQ-012 exp_vector  out  3  encodes 0 none, 1 load misaligned, 2 store misaligned, 3 load access fault, 4 store access fault.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 Access is active when (mem_r|mem_w) and !flush; if both mem_r and mem_w are high, the access SHALL be a store.
REQ-015 Alignment: a half access SHALL be misaligned if addr[0]=1; a word access SHALL be misaligned if addr[1:0]!=0; a byte access SHALL never be misaligned; u_b_h_w 011/110/111 SHALL be treated as word.
REQ-016 IDLE, active and misaligned: no dmem_req; stall=0; exp_vector=1 (load) or 2 (store) combinationally for that cycle; stay in IDLE.
REQ-017 IDLE, active and aligned: stall=1 combinationally; at the edge, register addr/be/wdata/we, set dmem_req=1 and go to BUSY.
REQ-018 BUSY: dmem_req, dmem_addr, dmem_be, dmem_we and dmem_wdata SHALL stay stable; stall=1; timeout counter increments each cycle.
REQ-019 BUSY with dmem_ack=1: drop dmem_req at the edge; for a load, register the extracted data; go to DONE.
REQ-020 BUSY, counter reaching TIMEOUT-1 without ack: drop dmem_req, latch fault, go to DONE.
REQ-021 DONE, lasting exactly one cycle: stall=0; load_valid=1 for a successful load; exp_vector=3 or 4 if faulted; next state IDLE; no new request is started in DONE.
REQ-022 Store lanes: sb SHALL replicate wdata[7:0] ×4 with be=0001<<addr[1:0]; sh SHALL replicate wdata[15:0] ×2 with be=0011<<addr[1:0]; sw SHALL use be=1111; dmem_addr={addr[31:2],2'b00}.
REQ-023 Loads SHALL drive dmem_we=0 and the same be pattern; data is dmem_rdata>>(8*addr[1:0]), then sign-extended (lb/lh) or zero-extended (lbu/lhu) to 32 bits.
REQ-024 Flush in BUSY SHALL NOT abort the bus transaction: set abort, keep stall=1 until ack or timeout; DONE then has load_valid=0 and exp_vector=0.
REQ-025 Flush in DONE SHALL suppress load_valid and exp_vector in that cycle.
REQ-026 dmem_ack outside BUSY SHALL be ignored.
REQ-027 Outside DONE, load_valid=0; load_data SHALL hold its last value.

Reset
REQ-028 rst SHALL force IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, load_data=0, load_valid=0, exp_vector=0, counter=0, abort=0; stall then follows REQ-016/017 combinationally.
REQ-029 rst asserted in BUSY SHALL drop dmem_req immediately; a subsequent late ack SHALL be ignored.

Verification
REQ-030 lb addr=0x1003, rdata=0x80xxxxxx, ack after 2 BUSY cycles -> stall high for 3 cycles, DONE load_data=0xFFFFFF80, load_valid=1.
REQ-031 sh addr=0x2002, wdata=0x1234ABCD -> dmem_wdata=0xABCDABCD, be=1100, we=1, dmem_addr=0x2000.
REQ-032 lw addr=0x3001 -> no dmem_req, stall=0, exp_vector=1 same cycle; sw addr=0x3002 -> exp_vector=2.
REQ-033 sw with ack never asserted, TIMEOUT=16 -> dmem_req high for 16 cycles, then DONE exp_vector=4, stall released.
REQ-034 lhu addr=0x4002, flush pulsed in BUSY, ack=1 with rdata=0xBEEF0000 -> DONE load_valid=0, exp_vector=0; a repeat without flush -> load_data=0x0000BEEF.
REQ-035 rst pulsed mid-BUSY, then ack -> dmem_req=0 within the reset, FSM in IDLE, no load_valid.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline and data-memory bus bundle for mem_access_unit
interface mem_access_unit_if;
    logic        flush;
    logic        mem_r;
    logic        mem_w;
    logic [2:0]  u_b_h_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic [2:0]  exp_vector;

    modport slave (
        input  flush, mem_r, mem_w, u_b_h_w, addr, wdata, dmem_ack, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output stall, load_data, load_valid, exp_vector
    );

    modport master (
        output flush, mem_r, mem_w, u_b_h_w, addr, wdata, dmem_ack, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  stall, load_data, load_valid, exp_vector
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with alignment check and bus timeout
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] load_data_q, load_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        fault_q, fault_d;
    logic [2:0]  funct_q, funct_d;
    logic [1:0]  off_q, off_d;

    logic        active, is_store, misaligned;
    size_t       size;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, shifted, load_ext;
    logic        stall;
    logic        load_valid;
    logic [2:0]  exp_vector;

    // Decode the incoming request: size, alignment and lane placement
    always_comb begin
        active   = (bus.mem_r | bus.mem_w) & ~bus.flush;
        is_store = bus.mem_w;
        case (bus.u_b_h_w[1:0])
            2'b00:   size = SZ_B;
            2'b01:   size = SZ_H;
            default: size = SZ_W;
        endcase
        misaligned = ((size == SZ_H) && bus.addr[0]) ||
                     ((size == SZ_W) && (bus.addr[1:0] != 2'b00));
        case (size)
            SZ_B: begin
                be_new    = 4'b0001 << bus.addr[1:0];
                wdata_new = {4{bus.wdata[7:0]}};
            end
            SZ_H: begin
                be_new    = 4'b0011 << bus.addr[1:0];
                wdata_new = {2{bus.wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = bus.wdata;
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        shifted = bus.dmem_rdata >> {off_q, 3'b000};
        case (funct_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Next-state and output logic of the IDLE/BUSY/DONE access FSM
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        load_data_d  = load_data_q;
        cnt_d        = cnt_q;
        abort_d      = abort_q;
        fault_d      = fault_q;
        funct_d      = funct_q;
        off_d        = off_q;
        stall        = 1'b0;
        load_valid   = 1'b0;
        exp_vector   = 3'd0;
        case (state_q)
            S_IDLE: begin
                if (active) begin
                    if (misaligned) begin
                        exp_vector = is_store ? 3'd2 : 3'd1;
                    end else begin
                        stall        = 1'b1;
                        state_d      = S_BUSY;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {bus.addr[31:2], 2'b00};
                        dmem_be_d    = be_new;
                        dmem_wdata_d = wdata_new;
                        funct_d      = bus.u_b_h_w;
                        off_d        = bus.addr[1:0];
                        cnt_d        = '0;
                        abort_d      = 1'b0;
                        fault_d      = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                // A flush cannot cancel an in-flight bus cycle; it only
                // suppresses the result once the cycle completes.
                stall   = 1'b1;
                abort_d = abort_q | bus.flush;
                if (bus.dmem_ack) begin
                    dmem_req_d = 1'b0;
                    if (!dmem_we_q) load_data_d = load_ext;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    dmem_req_d = 1'b0;
                    fault_d    = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!bus.flush && !abort_q) begin
                    if (fault_q) exp_vector = dmem_we_q ? 3'd4 : 3'd3;
                    else if (!dmem_we_q) load_valid = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and bus registers; async reset also drops an in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            load_data_q  <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            fault_q      <= 1'b0;
            funct_q      <= '0;
            off_q        <= '0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            load_data_q  <= load_data_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            fault_q      <= fault_d;
            funct_q      <= funct_d;
            off_q        <= off_d;
        end
    end

    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.load_data  = load_data_q;
    assign bus.load_valid = load_valid;
    assign bus.exp_vector = exp_vector;
    assign bus.stall      = stall;
endmodule
